// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default geometry of the output scratchpad,
// the ofmap element type and the packer state encoding.
package accel_pkg;

    localparam int SRAM_DATA_WIDTH_DFLT = 64;
    localparam int DATA_WIDTH_DFLT      = 8;
    localparam int ADDR_WIDTH_DFLT      = 8;
    localparam int LANES_DFLT           = SRAM_DATA_WIDTH_DFLT / (2 * DATA_WIDTH_DFLT);

    typedef logic signed [2*DATA_WIDTH_DFLT-1:0] ofmap_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } pack_state_e;

endpackage

// File: rtl/ofmap_packer_if.sv
// Ofmap stream in / output-SRAM write port out, bundled for the packer.
// master: the side producing ofmap elements and consuming SRAM writes.
// slave:  the packer itself.
interface ofmap_packer_if
    import accel_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DFLT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DFLT
);
    localparam int LANES = SRAM_DATA_WIDTH / (2 * DATA_WIDTH);

    logic signed [2*DATA_WIDTH-1:0] ofmap;
    logic                           ofmap_valid;
    logic                           done;

    logic                           write_en;
    logic [ADDR_WIDTH-1:0]          write_addr;
    logic [SRAM_DATA_WIDTH-1:0]     data_out;
    logic [LANES-1:0]               lane_mask;

    modport master (
        output ofmap, ofmap_valid, done,
        input  write_en, write_addr, data_out, lane_mask
    );

    modport slave (
        input  ofmap, ofmap_valid, done,
        output write_en, write_addr, data_out, lane_mask
    );

endinterface

// File: rtl/ofmap_packer.sv
// Ofmap packer: collects 2*DATA_WIDTH-bit ofmap elements into SRAM words,
// writes each full word to the output scratchpad and flushes a partial word
// (lane-masked) at end of stream.
// Optional build macro OFMAP_PACK_RELU_EN: negative elements are zeroed
// before packing (ReLU fused at writeback).
module ofmap_packer
    import accel_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DFLT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DFLT
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    ofmap_packer_if.slave         bus,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_overflow,
    output logic                  o_flush_done
);
    localparam int LANES = SRAM_DATA_WIDTH / (2 * DATA_WIDTH);
    localparam int EW    = 2 * DATA_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_WIDTH:0]  WC_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(LANES - 1);

    typedef logic signed [EW-1:0] elem_t;

    function automatic elem_t relu_fn(input elem_t x);
`ifdef OFMAP_PACK_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    pack_state_e                      state_q, state_d;
    logic [LANES-1:0][EW-1:0]         hold_q, hold_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]            base_q, base_d;
    logic                             base_vld_q, base_vld_d;
    logic [ADDR_WIDTH:0]              wc_q, wc_d;
    logic                             we_q, we_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0]       data_q, data_d;
    logic [LANES-1:0]                 mask_q, mask_d;
    logic                             ovf_q, ovf_d;
    logic                             fd_q, fd_d;

    logic                             commit;
    logic [SRAM_DATA_WIDTH-1:0]       commit_data;
    logic [LANES-1:0]                 commit_mask;
    elem_t                            elem;
    logic [ADDR_WIDTH-1:0]            base_eff;

    // Next-state logic: lane fill, word commit (full or partial), FSM and address generation.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        base_d      = base_q;
        base_vld_d  = base_vld_q;
        wc_d        = wc_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        ovf_d       = ovf_q;
        fd_d        = 1'b0;
        commit      = 1'b0;
        commit_data = '0;
        commit_mask = '0;
        elem        = relu_fn(bus.ofmap);
        // The base is latched on the first element; that same cycle it comes straight from the port.
        base_eff    = base_vld_q ? base_q : i_base_addr;

        unique case (state_q)
            ACCUM: begin
                if (bus.ofmap_valid) begin
                    hold_d[idx_q] = elem;
                    if (!base_vld_q) begin
                        base_d     = i_base_addr;
                        base_vld_d = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        commit      = 1'b1;
                        commit_data = hold_d;
                        commit_mask = '1;
                        hold_d      = '0;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (bus.done) begin
                    // A word completed by this same element already covers the flush.
                    if (!commit && idx_d != '0) begin
                        commit      = 1'b1;
                        commit_data = hold_d;
                        for (int k = 0; k < LANES; k++) begin
                            commit_mask[k] = (k < int'(idx_d));
                        end
                        hold_d = '0;
                        idx_d  = '0;
                    end
                    // With a write in flight, the flush pulse follows it from FLUSH.
                    state_d = commit ? FLUSH : DONE;
                    fd_d    = !commit;
                end
            end
            FLUSH: begin
                fd_d    = 1'b1;
                state_d = DONE;
            end
            default: begin
            end
        endcase

        if (commit) begin
            if (wc_q == WC_LIMIT) begin
                ovf_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = base_eff + wc_q[ADDR_WIDTH-1:0];
                data_d = commit_data;
                mask_d = commit_mask;
                wc_d   = wc_q + 1'b1;
            end
        end
    end

    // State and output registers; reset and clear both discard any partial word.
    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_reg_clear) begin
            state_q    <= ACCUM;
            hold_q     <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            base_vld_q <= 1'b0;
            wc_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            ovf_q      <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            base_vld_q <= base_vld_d;
            wc_q       <= wc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            ovf_q      <= ovf_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.write_en   = we_q;
    assign bus.write_addr = addr_q;
    assign bus.data_out   = data_q;
    assign bus.lane_mask  = mask_q;
    assign o_word_count   = wc_q;
    assign o_overflow     = ovf_q;
    assign o_flush_done   = fd_q;

endmodule
